bus_master_if: RTL and testbench

Bus-master interface: the initiator end of the shared 4-master/8-slave bus. It sits between one CPU pipeline memory port (IF or MEM stage) and one master slot of the bus, and runs the full request/grant/strobe/ready handshake. It holds the pipeline stalled while an access is in flight, returns read data, and aborts hung accesses with a watchdog.

---
 rtl/bus_master_if_pkg.sv | 21 ++
 rtl/bus_master_if_watchdog.sv | 33 +++
 rtl/bus_master_if.sv | 139 +++++++++++++
 tb/tb_bus_master_if.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_if_pkg.sv
// Shared bus header: word widths, transfer direction, active-low levels and
// the master FSM state encoding.
package bus_master_if_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int WD_W        = 8;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  localparam logic ENABLE_   = 1'b0;
  localparam logic DISABLE_  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACCESS = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_master_if_watchdog.sv
// Access watchdog: counts ACCESS cycles without slave ready and flags the
// cycle in which the count reaches TIMEOUT.
module bus_watchdog
  import bus_master_if_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_cnt_en,
  output logic o_expire
);

  // r_cnt holds the number of earlier waiting cycles, so the current one is
  // the TIMEOUT-th when r_cnt has reached TIMEOUT-1.
  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] r_cnt;

  assign o_expire = i_cnt_en && (r_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_cnt_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_master_if.sv
// Bus-master interface: runs the request/grant/strobe/ready handshake for one
// CPU memory port, stalls the pipeline while busy and aborts hung accesses.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_as_,
  input  logic                   cpu_rw,
  input  logic [WORD_ADDR_W-1:0] cpu_addr,
  input  logic [WORD_DATA_W-1:0] cpu_wr_data,
  input  logic                   stall,
  input  logic                   flush,
  output logic [WORD_DATA_W-1:0] cpu_rd_data,
  output logic                   busy,
  output logic                   bus_err,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_DATA_W-1:0] bus_wr_data,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_
);

  bus_state_e             r_state, w_state_nxt;
  logic                   r_req_, w_req_nxt;
  logic                   r_as_, w_as_nxt;
  logic                   r_rw, w_rw_nxt;
  logic                   r_err, w_err_nxt;
  logic [WORD_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [WORD_DATA_W-1:0] r_wr_data, w_wr_data_nxt;
  logic [WORD_DATA_W-1:0] r_rd_buf, w_rd_buf_nxt;
  logic                   w_accept, w_wd_clr, w_wd_en, w_expire, w_busy, w_rd_done;

  assign w_accept  = !cpu_as_ && !stall && !flush;
  assign w_wd_en   = (r_state == ST_ACCESS) && bus_rdy_;
  assign w_rd_done = (r_state == ST_ACCESS) && !bus_rdy_ && (r_rw == BUS_READ);

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (reset),
    .i_clr    (w_wd_clr),
    .i_cnt_en (w_wd_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req_;
    w_as_nxt      = DISABLE_;
    w_rw_nxt      = r_rw;
    w_err_nxt     = 1'b0;
    w_addr_nxt    = r_addr;
    w_wr_data_nxt = r_wr_data;
    w_rd_buf_nxt  = r_rd_buf;
    w_wd_clr      = 1'b0;
    w_busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_addr_nxt    = cpu_addr;
          w_rw_nxt      = cpu_rw;
          w_wr_data_nxt = cpu_wr_data;
          w_req_nxt     = ENABLE_;
          w_state_nxt   = ST_REQ;
          w_busy        = 1'b1;
        end
      end
      ST_REQ: begin
        // Flush wins over a same-cycle grant: nothing has reached the bus yet.
        if (flush) begin
          w_req_nxt   = DISABLE_;
          w_state_nxt = ST_IDLE;
        end else begin
          w_busy = 1'b1;
          if (bus_grnt_ == ENABLE_) begin
            w_as_nxt    = ENABLE_;
            w_wd_clr    = 1'b1;
            w_state_nxt = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (bus_rdy_ == ENABLE_) begin
          if (r_rw == BUS_READ) w_rd_buf_nxt = bus_rd_data;
          w_req_nxt   = DISABLE_;
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_rd_buf_nxt = '0;
          w_err_nxt    = 1'b1;
          w_req_nxt    = DISABLE_;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_busy = 1'b1;
        end
      end
      default: begin
        w_req_nxt   = DISABLE_;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_req_    <= DISABLE_;
      r_as_     <= DISABLE_;
      r_rw      <= BUS_READ;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_rd_buf  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req_    <= w_req_nxt;
      r_as_     <= w_as_nxt;
      r_rw      <= w_rw_nxt;
      r_err     <= w_err_nxt;
      r_addr    <= w_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_rd_buf  <= w_rd_buf_nxt;
    end
  end

  assign bus_req_    = r_req_;
  assign bus_as_     = r_as_;
  assign bus_rw      = r_rw;
  assign bus_addr    = r_addr;
  assign bus_wr_data = r_wr_data;
  assign bus_err     = r_err;
  assign busy        = w_busy;
  assign cpu_rd_data = w_rd_done ? bus_rd_data : r_rd_buf;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if (TIMEOUT=4): reset, zero-wait read, delayed
// write, flush, watchdog abort, back-to-back reads and asynchronous reset.
module tb_bus_master_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_as_, cpu_rw, stall, flush;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic [31:0] cpu_rd_data;
  logic        busy, bus_err, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_master_if #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_as_     (cpu_as_),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .stall       (stall),
    .flush       (flush),
    .cpu_rd_data (cpu_rd_data),
    .busy        (busy),
    .bus_err     (bus_err),
    .bus_req_    (bus_req_),
    .bus_grnt_   (bus_grnt_),
    .bus_addr    (bus_addr),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_as_     = 1'b1;
    cpu_rw      = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    bus_grnt_   = 1'b1;
    bus_rdy_    = 1'b1;
    bus_rd_data = 32'h0;
  endtask

  task automatic start_rd(input logic [29:0] a);
    cpu_as_  = 1'b0;
    cpu_rw   = 1'b1;
    cpu_addr = a;
  endtask

  initial begin
    reset       = 1'b1;
    cpu_addr    = '0;
    cpu_wr_data = '0;
    idle_inputs();
    mid();
    chk("rst_req", bus_req_, 1);
    chk("rst_as", bus_as_, 1);
    chk("rst_rw", bus_rw, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_rdata", cpu_rd_data, 0);
    nxt();
    reset = 1'b0;

    // Zero-wait read
    nxt(); start_rd(30'h100); bus_grnt_ = 1'b0;
    mid(); chk("r0_accept_busy", busy, 1); chk("r0_req_pre", bus_req_, 1);
    nxt();
    mid(); chk("r0_req", bus_req_, 0); chk("r0_as_req", bus_as_, 1);
    chk("r0_addr", bus_addr, 32'h100); chk("r0_rw", bus_rw, 1); chk("r0_busy_req", busy, 1);
    nxt(); bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
    mid(); chk("r0_as", bus_as_, 0); chk("r0_busy_done", busy, 0);
    chk("r0_rdata", cpu_rd_data, 32'hDEADBEEF);
    nxt(); idle_inputs(); bus_rd_data = 32'h55555555;
    mid(); chk("r0_as_after", bus_as_, 1); chk("r0_req_after", bus_req_, 1);
    chk("r0_rdata_hold", cpu_rd_data, 32'hDEADBEEF); chk("r0_busy_after", busy, 0);

    // Write, grant 4 cycles late, two wait states
    nxt(); cpu_as_ = 1'b0; cpu_rw = 1'b0; cpu_addr = 30'h200; cpu_wr_data = 32'h12345678;
    mid(); chk("w_accept_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      nxt();
      mid(); chk("w_req_wait", bus_req_, 0); chk("w_as_wait", bus_as_, 1); chk("w_busy_wait", busy, 1);
    end
    nxt(); bus_grnt_ = 1'b0;
    mid(); chk("w_as_grant", bus_as_, 1);
    nxt(); bus_grnt_ = 1'b1;
    mid(); chk("w_as", bus_as_, 0); chk("w_rw", bus_rw, 0);
    chk("w_wdata", bus_wr_data, 32'h12345678); chk("w_busy1", busy, 1);
    nxt();
    mid(); chk("w_as_ws2", bus_as_, 1); chk("w_req_ws2", bus_req_, 0);
    chk("w_busy2", busy, 1); chk("w_addr_ws2", bus_addr, 32'h200);
    nxt(); bus_rdy_ = 1'b0;
    mid(); chk("w_busy_done", busy, 0); chk("w_wdata_done", bus_wr_data, 32'h12345678);
    chk("w_rw_done", bus_rw, 0); chk("w_rdata_keep", cpu_rd_data, 32'hDEADBEEF);
    nxt(); idle_inputs();
    mid(); chk("w_req_after", bus_req_, 1); chk("w_rdata_after", cpu_rd_data, 32'hDEADBEEF);

    // Flush while ungranted
    nxt(); start_rd(30'h300);
    mid();
    nxt(); cpu_as_ = 1'b1; flush = 1'b1;
    mid(); chk("f1_busy", busy, 0); chk("f1_req", bus_req_, 0);
    nxt(); flush = 1'b0;
    mid(); chk("f1_req_rel", bus_req_, 1); chk("f1_as", bus_as_, 1);
    nxt();
    mid(); chk("f1_as2", bus_as_, 1);

    // Flush together with a grant
    nxt(); start_rd(30'h304);
    mid();
    nxt(); cpu_as_ = 1'b1; flush = 1'b1; bus_grnt_ = 1'b0;
    mid(); chk("f2_busy", busy, 0);
    nxt(); flush = 1'b0; bus_grnt_ = 1'b1;
    mid(); chk("f2_as", bus_as_, 1); chk("f2_req", bus_req_, 1);
    nxt();
    mid(); chk("f2_as2", bus_as_, 1); chk("f2_busy2", busy, 0);

    // Watchdog abort after 4 ACCESS cycles
    nxt(); start_rd(30'h400); bus_grnt_ = 1'b0; bus_rd_data = 32'hAAAAAAAA;
    mid();
    nxt();
    mid();
    for (int i = 1; i <= 3; i++) begin
      nxt();
      mid(); chk("to_busy", busy, 1); chk("to_err_pre", bus_err, 0);
    end
    nxt();
    mid(); chk("to_busy4", busy, 0); chk("to_err4_pre", bus_err, 0);
    nxt(); idle_inputs();
    mid(); chk("to_err", bus_err, 1); chk("to_rdata", cpu_rd_data, 0); chk("to_req", bus_req_, 1);
    nxt();
    mid(); chk("to_err_1cyc", bus_err, 0);

    // Ready in the 4th ACCESS cycle wins over the watchdog
    nxt(); start_rd(30'h404); bus_grnt_ = 1'b0;
    mid();
    nxt();
    mid();
    for (int i = 1; i <= 3; i++) begin
      nxt();
      mid(); chk("rl_busy", busy, 1);
    end
    nxt(); bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFEF00D;
    mid(); chk("rl_busy4", busy, 0); chk("rl_rdata", cpu_rd_data, 32'hCAFEF00D);
    nxt(); idle_inputs();
    mid(); chk("rl_err", bus_err, 0); chk("rl_rdata_hold", cpu_rd_data, 32'hCAFEF00D);

    // Back-to-back reads with cpu_as_ held low
    nxt(); start_rd(30'h500); bus_grnt_ = 1'b0;
    mid();
    nxt();
    mid(); chk("bb1_addr", bus_addr, 32'h500);
    nxt(); bus_rdy_ = 1'b0; bus_rd_data = 32'h11111111;
    mid(); chk("bb1_as", bus_as_, 0); chk("bb1_rdata", cpu_rd_data, 32'h11111111);
    nxt(); cpu_addr = 30'h504; bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    mid(); chk("bb_req_gap", bus_req_, 1); chk("bb_as_gap", bus_as_, 1);
    chk("bb_busy_gap", busy, 1); chk("bb1_hold", cpu_rd_data, 32'h11111111);
    nxt();
    mid(); chk("bb2_req", bus_req_, 0); chk("bb2_addr", bus_addr, 32'h504); chk("bb2_as_req", bus_as_, 1);
    nxt(); bus_rdy_ = 1'b0; bus_rd_data = 32'h22222222;
    mid(); chk("bb2_as", bus_as_, 0); chk("bb2_rdata", cpu_rd_data, 32'h22222222);
    nxt(); idle_inputs();
    mid(); chk("bb2_hold", cpu_rd_data, 32'h22222222); chk("bb2_req_after", bus_req_, 1);

    // Asynchronous reset in the middle of an access
    nxt(); start_rd(30'h600); bus_grnt_ = 1'b0;
    mid();
    nxt();
    mid();
    nxt(); cpu_as_ = 1'b1; bus_grnt_ = 1'b1;
    #2; chk("ar_as_pre", bus_as_, 0);
    reset = 1'b1;
    #1;
    chk("ar_req", bus_req_, 1); chk("ar_as", bus_as_, 1); chk("ar_rw", bus_rw, 1);
    chk("ar_busy", busy, 0); chk("ar_rdata", cpu_rd_data, 0); chk("ar_addr", bus_addr, 0);
    nxt(); reset = 1'b0;
    mid(); chk("ar_idle_busy", busy, 0); chk("ar_idle_req", bus_req_, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
